// File: rtl/mmio_ctrl_hs_if.sv
// FPro MMIO bus bundle between the bus bridge (master) and the slot controller (slave).
interface mmio_ctrl_hs_if #(
    parameter int DW = 32
) ();
    logic          mmio_cs;
    logic          mmio_wr;
    logic          mmio_rd;
    logic [20:0]   mmio_addr;
    logic [DW-1:0] mmio_wr_data;
    logic [DW-1:0] mmio_rd_data;
    logic          mmio_ready;
    logic          mmio_err;
    logic          mmio_busy;

    modport master (
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        input  mmio_rd_data, mmio_ready, mmio_err, mmio_busy
    );

    modport slave (
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        output mmio_rd_data, mmio_ready, mmio_err, mmio_busy
    );
endinterface

// File: rtl/mmio_ctrl_hs.sv
// MMIO slot controller: decodes bus accesses to one of N_SLOTS slots and runs a
// req/ack handshake with wait states, a timeout and unmapped-slot detection.
module mmio_ctrl_hs #(
    parameter int                 N_SLOTS      = 64,
    parameter int                 SLOT_AW      = 6,
    parameter int                 REG_AW       = 5,
    parameter int                 DW           = 32,
    parameter logic [N_SLOTS-1:0] SLOT_PRESENT = '1,
    parameter int                 TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    mmio_ctrl_hs_if.slave              mmio,
    output logic [N_SLOTS-1:0]         slot_cs_array,
    output logic [N_SLOTS-1:0]         slot_mem_rd_array,
    output logic [N_SLOTS-1:0]         slot_mem_wr_array,
    output logic [REG_AW-1:0]          slot_reg_addr,
    output logic [DW-1:0]              slot_wr_data,
    input  logic [N_SLOTS-1:0][DW-1:0] slot_rd_data_array,
    input  logic [N_SLOTS-1:0]         slot_ack_array
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_r, next_state_s;
    logic [N_SLOTS-1:0]  sel_r, sel_nx_s, req_sel_s;
    logic                wr_r, wr_nx_s;
    logic                err_r, err_nx_s;
    logic [DW-1:0]       cap_r, cap_nx_s;
    logic [DW-1:0]       wdata_r, wdata_nx_s;
    logic [REG_AW-1:0]   reg_r, reg_nx_s;
    logic [15:0]         cnt_r, cnt_nx_s;
    logic [SLOT_AW-1:0]  req_slot_s;
    logic [DW-1:0]       sel_rd_data_s;
    logic                accept_s, req_bad_s, sel_ack_s, timeout_s;
    logic                unused_addr_s;

    logic [N_SLOTS-1:0]  cs_r, rd_stb_r, wr_stb_r;
    logic [N_SLOTS-1:0]  cs_nx_s, rd_stb_nx_s, wr_stb_nx_s;
    logic                ready_r, ready_nx_s, err_out_r, err_out_nx_s, busy_r, busy_nx_s;
    logic [DW-1:0]       rd_data_r, rd_data_nx_s;

    assign unused_addr_s = ^mmio.mmio_addr[20:REG_AW+SLOT_AW];
    assign req_slot_s    = mmio.mmio_addr[REG_AW+SLOT_AW-1:REG_AW];

    // Address-to-slot one-hot decode (absent/out-of-range slots give all zeros) and selected-slot read mux
    always_comb begin
        req_sel_s     = '0;
        sel_rd_data_s = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            req_sel_s[i]  = (int'(req_slot_s) == i) && SLOT_PRESENT[i];
            sel_rd_data_s = sel_rd_data_s | (slot_rd_data_array[i] & {DW{sel_r[i]}});
        end
    end

    assign accept_s  = mmio.mmio_cs & (mmio.mmio_rd | mmio.mmio_wr);
    assign req_bad_s = (mmio.mmio_rd & mmio.mmio_wr) | ~(|req_sel_s);
    assign sel_ack_s = |(slot_ack_array & sel_r);
    assign timeout_s = (cnt_r == 16'(TIMEOUT - 1));

    // State and latched-transaction registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            wr_r    <= 1'b0;
            err_r   <= 1'b0;
            cap_r   <= '0;
            wdata_r <= '0;
            reg_r   <= '0;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= next_state_s;
            sel_r   <= sel_nx_s;
            wr_r    <= wr_nx_s;
            err_r   <= err_nx_s;
            cap_r   <= cap_nx_s;
            wdata_r <= wdata_nx_s;
            reg_r   <= reg_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state and next transaction contents
    always_comb begin
        next_state_s = state_r;
        sel_nx_s     = sel_r;
        wr_nx_s      = wr_r;
        err_nx_s     = err_r;
        cap_nx_s     = cap_r;
        wdata_nx_s   = wdata_r;
        reg_nx_s     = reg_r;
        cnt_nx_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sel_nx_s     = req_bad_s ? '0 : req_sel_s;
                    wr_nx_s      = mmio.mmio_wr;
                    err_nx_s     = req_bad_s;
                    cap_nx_s     = '0;
                    wdata_nx_s   = mmio.mmio_wr_data;
                    reg_nx_s     = mmio.mmio_addr[REG_AW-1:0];
                    cnt_nx_s     = 16'd0;
                    next_state_s = req_bad_s ? ST_DONE : ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (sel_ack_s) begin
                    cap_nx_s     = wr_r ? '0 : sel_rd_data_s;
                    next_state_s = ST_DONE;
                end else begin
                    cnt_nx_s     = 16'd0;
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack in the final wait cycle still wins over the timeout
                if (sel_ack_s) begin
                    cap_nx_s     = wr_r ? '0 : sel_rd_data_s;
                    next_state_s = ST_DONE;
                end else if (timeout_s) begin
                    err_nx_s     = 1'b1;
                    cap_nx_s     = '0;
                    next_state_s = ST_DONE;
                end else begin
                    cnt_nx_s     = cnt_r + 16'd1;
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        cs_nx_s      = '0;
        rd_stb_nx_s  = '0;
        wr_stb_nx_s  = '0;
        ready_nx_s   = 1'b0;
        err_out_nx_s = 1'b0;
        busy_nx_s    = 1'b0;
        rd_data_nx_s = '0;
        case (next_state_s)
            ST_IDLE: begin
                busy_nx_s = 1'b0;
            end
            ST_ACCESS: begin
                cs_nx_s     = sel_nx_s;
                rd_stb_nx_s = wr_nx_s ? '0 : sel_nx_s;
                wr_stb_nx_s = wr_nx_s ? sel_nx_s : '0;
                busy_nx_s   = 1'b1;
            end
            ST_WAIT: begin
                cs_nx_s   = sel_nx_s;
                busy_nx_s = 1'b1;
            end
            ST_DONE: begin
                ready_nx_s   = 1'b1;
                err_out_nx_s = err_nx_s;
                rd_data_nx_s = cap_nx_s;
                busy_nx_s    = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_r      <= '0;
            rd_stb_r  <= '0;
            wr_stb_r  <= '0;
            ready_r   <= 1'b0;
            err_out_r <= 1'b0;
            busy_r    <= 1'b0;
            rd_data_r <= '0;
        end else begin
            cs_r      <= cs_nx_s;
            rd_stb_r  <= rd_stb_nx_s;
            wr_stb_r  <= wr_stb_nx_s;
            ready_r   <= ready_nx_s;
            err_out_r <= err_out_nx_s;
            busy_r    <= busy_nx_s;
            rd_data_r <= rd_data_nx_s;
        end
    end

    assign slot_cs_array     = cs_r;
    assign slot_mem_rd_array = rd_stb_r;
    assign slot_mem_wr_array = wr_stb_r;
    assign slot_reg_addr     = reg_r;
    assign slot_wr_data      = wdata_r;
    assign mmio.mmio_ready   = ready_r;
    assign mmio.mmio_err     = err_out_r;
    assign mmio.mmio_busy    = busy_r;
    assign mmio.mmio_rd_data = rd_data_r;

endmodule

// File: doc/mmio_ctrl_hs.md
Name: mmio_ctrl_hs

Overview:
- Parametrised MMIO slot controller: decodes FPro-bus MMIO accesses to one of N_SLOTS peripheral slots and runs a request/acknowledge handshake with the selected slot.
- Strobes only the addressed slot; nothing is broadcast to idle slots.
- Returns registered read data with completion and error flags.
- Sits between the FPro bus bridge and the peripheral slot array.
- Adds wait-state support, a timeout and unmapped-slot detection.

Parameters:
- N_SLOTS, 64: number of slots; legal range 2..64.
- SLOT_AW, 6: slot address width; must satisfy 2**SLOT_AW >= N_SLOTS.
- REG_AW, 5: register address width inside a slot.
- DW, 32: data width.
- SLOT_PRESENT, all ones (N_SLOTS bits): bit i = 1 means slot i is populated.
- TIMEOUT, 255: maximum WAIT cycles before an access is aborted; legal range 1..65535.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- mmio_cs, input, 1: MMIO request select.
- mmio_wr, input, 1: write request.
- mmio_rd, input, 1: read request.
- mmio_addr, input, 21: bits [REG_AW+SLOT_AW-1:REG_AW] give the slot; bits [REG_AW-1:0] give the register; upper bits are ignored.
- mmio_wr_data, input, DW: write data.
- mmio_rd_data, output, DW: read data; valid while mmio_ready is high.
- mmio_ready, output, 1: one-cycle completion pulse.
- mmio_err, output, 1: error flag; qualifies mmio_ready.
- mmio_busy, output, 1: high from request acceptance until the mmio_ready cycle, inclusive.
- slot_cs_array, output, N_SLOTS: one-hot select of the active slot.
- slot_mem_rd_array, output, N_SLOTS: read strobe to the selected slot only.
- slot_mem_wr_array, output, N_SLOTS: write strobe to the selected slot only.
- slot_reg_addr, output, REG_AW: latched register address, shared by all slots.
- slot_wr_data, output, DW: latched write data, shared by all slots.
- slot_rd_data_array, input, DW x N_SLOTS: per-slot read data.
- slot_ack_array, input, N_SLOTS: per-slot acknowledge.

Behaviour:
- Reset (asynchronous, reset low):
  - State = IDLE.
  - All outputs = 0.
  - Internal address, data and counter registers = 0.
  - Reset during any state aborts the access: no mmio_ready is produced and strobes drop immediately.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - A request is accepted at a rising edge when mmio_cs=1 and exactly one of mmio_rd / mmio_wr is high.
  - On acceptance, latch slot index, register address, write data and direction; set mmio_busy.
  - mmio_rd = mmio_wr = 1 with mmio_cs: accepted as an error; go to DONE with err=1; no slot is strobed.
  - Slot index >= N_SLOTS or SLOT_PRESENT[idx]=0: go to DONE with err=1; no slot is strobed.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - slot_cs_array[idx]=1 and the rd or wr strobe for idx = 1; all other bits 0.
  - If slot_ack_array[idx]=1 in this cycle: capture read data and go to DONE.
  - Otherwise clear the counter and go to WAIT.
- WAIT:
  - slot_cs_array[idx] stays high; the rd/wr strobe is low (single-cycle strobe semantics).
  - slot_ack_array[idx]=1: capture slot_rd_data_array[idx] and go to DONE.
  - Counter == TIMEOUT-1 with no ack: go to DONE with err=1 and read data 0.
  - Otherwise increment the counter.
- DONE (1 cycle):
  - mmio_ready=1; mmio_err as determined; mmio_rd_data = captured data (0 for writes and errors).
  - mmio_busy=1 in this cycle; next state IDLE.
- Latency from the accepting edge:
  - Ack in ACCESS: mmio_ready at cycle +2.
  - Ack after k WAIT cycles: mmio_ready at cycle +2+k.
  - Error detected in IDLE: mmio_ready at cycle +1.
- Requests presented while busy (any state other than IDLE) are ignored; the master must wait for mmio_ready.
- A new request may be accepted in the first IDLE cycle after DONE.
- Acks from non-selected slots, and any ack while IDLE, are ignored.
- mmio_rd_data holds its value only during DONE and returns to 0 afterwards.

Test Plan:
- Read slot 3, reg 7 (mmio_addr=0x067); slot 3 acks in ACCESS with 0xCAFE0001 → exactly one strobe on slot_mem_rd_array[3]; mmio_ready at +2 with mmio_rd_data=0xCAFE0001 and err=0.
- Write 0x12345678 to slot 10, reg 2; ack after 5 WAIT cycles → slot_cs_array[10] high for 6 cycles; wr strobe for 1 cycle; slot_wr_data=0x12345678; mmio_ready at +7 with err=0.
- N_SLOTS=8, read slot 9; separately, read a slot whose SLOT_PRESENT bit is 0 → no slot_cs asserted; mmio_ready at +1 with err=1 and rd_data=0.
- TIMEOUT=4, read slot 1 that never acks → mmio_ready at +6 with err=1, rd_data=0; the next request is accepted normally.
- mmio_rd=mmio_wr=1 → err response at +1 with no strobes; a new request during WAIT is ignored and the first request completes unchanged.
- Assert reset mid-WAIT → all outputs 0 asynchronously and no mmio_ready; after release, a read to slot 0 completes normally.
